hazard_stall_ctrl: RTL and testbench

Hazard and stall controller for the 5-stage MIPS pipeline. It drives the program counter's hold input and the IF/ID and ID/EX pipeline-register control signals. It detects three conditions:
- load-use hazards, resolved with a 1-cycle bubble;
- taken branches resolved in ID, resolved with an IF/ID flush;
- multi-cycle multiply/divide occupancy, resolved with a counted stall.

The block is the producer side of the PC hold interface: pc_stall=1 means the PC keeps its current value.

---
 rtl/hazard_stall_ctrl.sv | 103 ++++++++++
 tb/tb_hazard_stall_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use bubble, ID branch flush, mult/div occupancy stall.
// Optional stall-cycle performance counter enabled by defining HAZARD_STALL_CNT_EN.
module hazard_stall_ctrl #(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned REG_AW     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              id_branch_taken,
    input  logic              id_md_start,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              md_busy,
    output logic [31:0]       stall_cycles
);

    localparam int unsigned CNT_W = $clog2(MD_LATENCY) + 1;

    localparam logic [0:0] RUN     = 1'b0;
    localparam logic [0:0] MD_BUSY = 1'b1;

    logic [0:0]       state, state_nxt;
    logic [CNT_W-1:0] md_cnt, md_cnt_nxt;
    logic             lu;

    // Load in EX feeding a source of the instruction in ID; r0 never creates a hazard.
    assign lu = ex_memread && (ex_rt != '0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        md_cnt_nxt = md_cnt;
        pc_stall   = 1'b0;
        ifid_stall = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        md_busy    = 1'b0;
        if (rst) begin
            case (state)
                RUN: begin
                    if (lu) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_flush = 1'b1;
                    end else begin
                        ifid_flush = id_branch_taken;
                        if (id_md_start) begin
                            state_nxt  = MD_BUSY;
                            md_cnt_nxt = CNT_W'(MD_LATENCY - 1);
                        end
                    end
                end
                MD_BUSY: begin
                    md_busy    = 1'b1;
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_flush = 1'b1;
                    if (md_cnt == '0) begin
                        state_nxt = RUN;
                    end else begin
                        md_cnt_nxt = md_cnt - CNT_W'(1);
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt;

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (pc_stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances (MD_LATENCY 4 and 1) on shared stimulus,
// vector table, directed multi-cycle sequences and random stimulus against a reference model.
module tb_hazard_stall_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_memread, id_branch_taken, id_md_start;

    logic        pc4, ifs4, iff4, idf4, mb4;
    logic [31:0] sc4;
    logic        pc1, ifs1, iff1, idf1, mb1;
    logic [31:0] sc1;

    int total = 0;
    int bad   = 0;

    // Reference state: remaining occupancy cycles and stall-cycle counts
    int          rem4 = 0;
    int          rem1 = 0;
    logic [31:0] cnt4 = 32'd0;
    logic [31:0] cnt1 = 32'd0;

    hazard_stall_ctrl #(.MD_LATENCY(4), .REG_AW(5)) dut4 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .id_branch_taken(id_branch_taken),
        .id_md_start(id_md_start), .pc_stall(pc4), .ifid_stall(ifs4), .ifid_flush(iff4),
        .idex_flush(idf4), .md_busy(mb4), .stall_cycles(sc4)
    );

    hazard_stall_ctrl #(.MD_LATENCY(1), .REG_AW(5)) dut1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .id_branch_taken(id_branch_taken),
        .id_md_start(id_md_start), .pc_stall(pc1), .ifid_stall(ifs1), .ifid_flush(iff1),
        .idex_flush(idf1), .md_busy(mb1), .stall_cycles(sc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses;
        logic       mr;
        logic [4:0] exrt;
        logic       br;
        logic       md;
        logic [4:0] exp;   // {md_busy, pc_stall, ifid_stall, ifid_flush, idex_flush}
    } vec_t;

    vec_t tbl[9];

    localparam logic [4:0] QUIET = 5'b00000;
    localparam logic [4:0] BUBL  = 5'b01101;
    localparam logic [4:0] FLUSH = 5'b00010;
    localparam logic [4:0] BUSY  = 5'b11101;

    function automatic logic [4:0] out4();
        return {mb4, pc4, ifs4, iff4, idf4};
    endfunction

    function automatic logic [4:0] out1();
        return {mb1, pc1, ifs1, iff1, idf1};
    endfunction

    function automatic bit lu_m();
        return ex_memread && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

    // Expected outputs from the remaining-occupancy count and the current inputs
    function automatic logic [4:0] model_out(int rem);
        if (!rst)     return QUIET;
        if (rem > 0)  return BUSY;
        if (lu_m())   return BUBL;
        return id_branch_taken ? FLUSH : QUIET;
    endfunction

    function automatic int next_rem(int rem, int lat);
        if (!rst)                        return 0;
        if (rem > 0)                     return rem - 1;
        if (!lu_m() && id_md_start)      return lat;
        return 0;
    endfunction

    function automatic logic [31:0] next_cnt(logic [31:0] c, int rem);
        logic [4:0] o;
        o = model_out(rem);
        if (!rst) return 32'd0;
        if (o[3] && c != 32'hFFFF_FFFF) return c + 32'd1;
        return c;
    endfunction

    task automatic cmp(input string name, input string which, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s/%s: got %h want %h at %0t", name, which, act, exp, $time);
        end
    endtask

    task automatic check_model(input string name);
        cmp(name, "out_l4", 32'(out4()), 32'(model_out(rem4)));
        cmp(name, "out_l1", 32'(out1()), 32'(model_out(rem1)));
`ifdef HAZARD_STALL_CNT_EN
        cmp(name, "cnt_l4", sc4, cnt4);
        cmp(name, "cnt_l1", sc1, cnt1);
`else
        cmp(name, "cnt_l4", sc4, 32'd0);
        cmp(name, "cnt_l1", sc1, 32'd0);
`endif
    endtask

    // Advance one clock: update the model at the edge, return at the next negedge
    task automatic tick();
        @(posedge clk);
        cnt4 = next_cnt(cnt4, rem4);
        cnt1 = next_cnt(cnt1, rem1);
        rem4 = next_rem(rem4, 4);
        rem1 = next_rem(rem1, 1);
        @(negedge clk);
    endtask

    task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                         input logic mr, input logic [4:0] exrt, input logic br, input logic md);
        rst = r; id_rs = rs; id_rt = rt; id_uses_rt = uses;
        ex_memread = mr; ex_rt = exrt; id_branch_taken = br; id_md_start = md;
    endtask

    task automatic quiet();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        tbl[0] = '{1'b1, 5'd3, 5'd8, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, BUBL};
        tbl[1] = '{1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, QUIET};
        tbl[2] = '{1'b1, 5'd3, 5'd8, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, QUIET};
        tbl[3] = '{1'b1, 5'd3, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, FLUSH};
        tbl[4] = '{1'b1, 5'd7, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, BUBL};
        tbl[5] = '{1'b1, 5'd9, 5'd2, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0, QUIET};
        tbl[6] = '{1'b1, 5'd9, 5'd2, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, BUBL};
        tbl[7] = '{1'b0, 5'd9, 5'd2, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, QUIET};
        tbl[8] = '{1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1, BUBL};

        drive(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        @(negedge clk);

        // Reset held with a live load-use pattern: everything quiet
        for (int i = 0; i < 3; i++) begin
            #1;
            cmp("reset_hold", "out_l4", 32'(out4()), 32'(QUIET));
            check_model("reset_hold");
            tick();
        end
        rst = 1'b1;
        #1;
        cmp("reset_release", "out_l4", 32'(out4()), 32'(BUBL));
        check_model("reset_release");
        tick();

        // Single-cycle vector table, each applied from RUN
        quiet();
        tick();
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].rst, tbl[i].rs, tbl[i].rt, tbl[i].uses, tbl[i].mr, tbl[i].exrt, tbl[i].br, tbl[i].md);
            #1;
            cmp($sformatf("vec%0d", i), "out_l4", 32'(out4()), 32'(tbl[i].exp));
            cmp($sformatf("vec%0d", i), "out_l1", 32'(out1()), 32'(tbl[i].exp));
            check_model($sformatf("vec%0d", i));
            tick();
        end

        // Mult/div issue with a taken branch in the same cycle, then occupancy
        quiet();
        id_md_start = 1'b1;
        id_branch_taken = 1'b1;
        #1;
        cmp("md_issue", "out_l4", 32'(out4()), 32'(FLUSH));
        check_model("md_issue");
        tick();
        for (int k = 1; k <= 5; k++) begin
            quiet();
            ex_memread = 1'b1; ex_rt = 5'd6; id_rs = 5'd6;  // hazard ignored while busy
            id_md_start = (k == 5) ? 1'b0 : 1'b1;
            #1;
            cmp($sformatf("md_T+%0d", k), "out_l4", 32'(out4()), 32'((k <= 4) ? BUSY : BUBL));
            cmp($sformatf("md_T+%0d", k), "out_l1", 32'(out1()), 32'((k <= 1) ? BUSY : BUBL));
            check_model($sformatf("md_T+%0d", k));
            tick();
        end

        // Back-to-back: held mult/div issues on first RUN cycle and re-enters busy
        quiet();
        id_md_start = 1'b1;
        #1;
        check_model("b2b_issue");
        tick();
        for (int k = 1; k <= 5; k++) begin
            id_md_start = 1'b1;
            #1;
            check_model($sformatf("b2b_T+%0d", k));
            tick();
        end
        quiet();
        for (int k = 0; k < 5; k++) begin
            #1;
            check_model("b2b_drain");
            tick();
        end

        // Reset asserted in the middle of an occupancy
        quiet();
        id_md_start = 1'b1;
        #1;
        check_model("rstbusy_issue");
        tick();
        quiet();
        #1;
        cmp("rstbusy_T+1", "out_l4", 32'(out4()), 32'(BUSY));
        tick();
        rst = 1'b0;
        #1;
        cmp("rstbusy_T+2", "out_l4", 32'(out4()), 32'(QUIET));
        check_model("rstbusy_T+2");
        tick();
        quiet();
        for (int k = 0; k < 2; k++) begin
            #1;
            cmp("rstbusy_after", "out_l4", 32'(out4()), 32'(QUIET));
            check_model("rstbusy_after");
            tick();
        end

        // Counter: one load-use bubble plus one occupancy
        rst = 1'b0;
        tick();
        drive(1'b1, 5'd3, 5'd8, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
        tick();
        quiet();
        id_md_start = 1'b1;
        tick();
        quiet();
        for (int k = 0; k < 6; k++) tick();
        #1;
`ifdef HAZARD_STALL_CNT_EN
        cmp("counter", "cnt_l4", sc4, 32'd5);
        cmp("counter", "cnt_l1", sc1, 32'd2);
`else
        cmp("counter", "cnt_l4", sc4, 32'd0);
        cmp("counter", "cnt_l1", sc1, 32'd0);
`endif
        check_model("counter");

        // Random stimulus against the reference model
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 39) != 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
            #1;
            check_model($sformatf("rand%0d", n));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
